alu_pipe_stream: RTL and testbench

//  Parametrised 2-stage pipelined ALU with valid/ready handshake on input and output, full backpressure,
//  a per-op tag, and flags computed from the current result. Throughput is one op per clock.

---
 rtl/alu_pipe_stream.sv | 162 ++++++++++++++++
 tb/tb_alu_pipe_stream.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_stream.sv
// Two-stage pipelined ALU with tag passthrough and per-result flags.
// Latency: two clock edges from input accept to out_valid; one op per clock sustained.
// Backpressure: out_ready low holds S2 stable, S1 fills, then in_ready drops (2 ops held max).
module alu_pipe_stream #(
  parameter int WIDTH   = 64,
  parameter int SHIFT_W = $clog2(WIDTH),
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_opcode,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [SHIFT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_carry,
  output logic               out_zero,
  output logic               out_ovf,
  output logic               out_sign,
  output logic               out_illegal
);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_MUL  = 4'd2,  OP_SRA  = 4'd3;
  localparam logic [3:0] OP_NAND = 4'd4,  OP_SLL  = 4'd5,  OP_MAXU = 4'd6,  OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8,  OP_AND  = 4'd9,  OP_OR   = 4'd10, OP_XOR  = 4'd11;
  localparam logic [3:0] OP_MINU = 4'd12, OP_SLTU = 4'd13;

  // Stage 1 holding registers
  logic               s1_valid_q;
  logic [3:0]         s1_op_q;
  logic [WIDTH-1:0]   s1_a_q, s1_b_q;
  logic [SHIFT_W-1:0] s1_shamt_q;
  logic [TAG_W-1:0]   s1_tag_q;

  // Stage 2 (output) registers
  logic               out_valid_q;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [TAG_W-1:0]   tag_q;
  logic               carry_q, carry_d, zero_q, ovf_q, ovf_d, sign_q, ill_q, ill_d;

  logic s2_load, in_accept;

  assign s2_load   = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready  = !s1_valid_q || s2_load;
  assign in_accept = in_valid && in_ready;

  // Widened datapaths so carry/borrow and shifted-out bits fall out of the same operation
  logic [WIDTH:0]          add_w, sll_w, srl_w, sra_w;
  logic [WIDTH-1:0]        sub_r;
  logic [2*WIDTH-1:0]      mul_w;
  logic signed [WIDTH:0]   sra_in;

  assign add_w  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
  assign sub_r  = s1_a_q - s1_b_q;
  assign mul_w  = {{WIDTH{1'b0}}, s1_a_q} * {{WIDTH{1'b0}}, s1_b_q};
  assign sll_w  = {1'b0, s1_a_q} << s1_shamt_q;
  assign srl_w  = {s1_a_q, 1'b0} >> s1_shamt_q;
  assign sra_in = {s1_a_q, 1'b0};
  assign sra_w  = sra_in >>> s1_shamt_q;

  // Result and carry/overflow selection for the op sitting in S1
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    ill_d   = 1'b0;
    case (s1_op_q)
      OP_ADD: begin
        res_d   = add_w[WIDTH-1:0];
        carry_d = add_w[WIDTH];
        ovf_d   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (add_w[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = sub_r;
        carry_d = s1_a_q < s1_b_q;
        ovf_d   = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (sub_r[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      OP_MUL: begin
        res_d = mul_w[WIDTH-1:0];
        ovf_d = |mul_w[2*WIDTH-1:WIDTH];
      end
      OP_SRA:  begin res_d = sra_w[WIDTH:1]; carry_d = sra_w[0]; end
      OP_SLL:  begin res_d = sll_w[WIDTH-1:0]; carry_d = sll_w[WIDTH]; end
      OP_SRL:  begin res_d = srl_w[WIDTH:1]; carry_d = srl_w[0]; end
      OP_NAND: res_d = ~(s1_a_q & s1_b_q);
      OP_AND:  res_d = s1_a_q & s1_b_q;
      OP_OR:   res_d = s1_a_q | s1_b_q;
      OP_XOR:  res_d = s1_a_q ^ s1_b_q;
      OP_MAXU: res_d = (s1_a_q >= s1_b_q) ? s1_a_q : s1_b_q;
      OP_MINU: res_d = (s1_a_q <= s1_b_q) ? s1_a_q : s1_b_q;
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, $signed(s1_a_q) < $signed(s1_b_q)};
      OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, s1_a_q < s1_b_q};
      default: ill_d = 1'b1;
    endcase
  end

  // S1 captures on accept and empties when its op moves to S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_shamt_q <= '0;
      s1_tag_q   <= '0;
    end else begin
      if (in_accept) begin
        s1_valid_q <= 1'b1;
        s1_op_q    <= in_opcode;
        s1_a_q     <= in_a;
        s1_b_q     <= in_b;
        s1_shamt_q <= in_shamt;
        s1_tag_q   <= in_tag;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  // S2 registers the result; zero/sign come from the new result, not the held one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      tag_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      sign_q      <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid_q <= 1'b1;
        res_q       <= res_d;
        tag_q       <= s1_tag_q;
        carry_q     <= carry_d;
        zero_q      <= (res_d == '0);
        ovf_q       <= ovf_d;
        sign_q      <= res_d[WIDTH-1];
        ill_q       <= ill_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = res_q;
  assign out_tag     = tag_q;
  assign out_carry   = carry_q;
  assign out_zero    = zero_q;
  assign out_ovf     = ovf_q;
  assign out_sign    = sign_q;
  assign out_illegal = ill_q;

endmodule

// File: tb/tb_alu_pipe_stream.sv
// Randomised + directed bench for alu_pipe_stream with a queue scoreboard.
module tb_alu_pipe_stream;

  localparam int W  = 64;
  localparam int SW = 6;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [3:0]    in_opcode = '0;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic [SW-1:0] in_shamt = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid, out_ready = 1'b1;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;
  logic          out_carry, out_zero, out_ovf, out_sign, out_illegal;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [W-1:0]  r;
    logic          c, z, o, s, i;
  } res_t;

  res_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   rand_done;

  always #5 clk = ~clk;

  alu_pipe_stream #(.WIDTH(W), .SHIFT_W(SW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_a(in_a), .in_b(in_b), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_carry(out_carry), .out_zero(out_zero),
    .out_ovf(out_ovf), .out_sign(out_sign), .out_illegal(out_illegal)
  );

  // Reference model: the op table evaluated with plain 128-bit arithmetic
  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [SW-1:0] sh, input logic [TW-1:0] tag);
    res_t e;
    logic [2*W-1:0] w;
    int s;
    e = '0;
    e.tag = tag;
    s = int'(sh);
    case (op)
      4'd0: begin w = {64'd0, a} + {64'd0, b}; e.r = w[W-1:0]; e.c = w[W];
                  e.o = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]); end
      4'd1: begin e.r = a - b; e.c = (a < b); e.o = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]); end
      4'd2: begin w = {64'd0, a} * {64'd0, b}; e.r = w[W-1:0]; e.o = (w[2*W-1:W] != 0); end
      4'd3: begin e.r = W'($signed(a) >>> s); e.c = (s == 0) ? 1'b0 : a[s-1]; end
      4'd4: e.r = ~(a & b);
      4'd5: begin e.r = a << s; e.c = (s == 0) ? 1'b0 : a[W-s]; end
      4'd6: e.r = (a >= b) ? a : b;
      4'd7: e.r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd8: begin e.r = a >> s; e.c = (s == 0) ? 1'b0 : a[s-1]; end
      4'd9: e.r = a & b;
      4'd10: e.r = a | b;
      4'd11: e.r = a ^ b;
      4'd12: e.r = (a <= b) ? a : b;
      4'd13: e.r = (a < b) ? 64'd1 : 64'd0;
      default: e.i = 1'b1;
    endcase
    e.z = (e.r == 0);
    e.s = e.r[W-1];
    return e;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare the head of the scoreboard whenever a result is presented; pop on transfer
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      res_t act;
      act = {out_tag, out_result, out_carry, out_zero, out_ovf, out_sign, out_illegal};
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got tag=%h r=%h, expected no output", out_tag, out_result);
      end else begin
        if (act !== sb[0]) begin
          n_fail++;
          $display("FAIL result: got tag=%h r=%h c%b z%b o%b s%b i%b expected tag=%h r=%h c%b z%b o%b s%b i%b",
                   act.tag, act.r, act.c, act.z, act.o, act.s, act.i,
                   sb[0].tag, sb[0].r, sb[0].c, sb[0].z, sb[0].o, sb[0].s, sb[0].i);
        end
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // Called at posedge+1; offers one op, returns at posedge+1 after it transferred
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [SW-1:0] sh, input logic [TW-1:0] tag);
    bit done;
    done = 0;
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b; in_shamt = sh; in_tag = tag;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(op, a, b, sh, tag));
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, expected accept");
    end
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results outstanding, expected 0", sb.size());
    end
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return W'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    #12;
    check("reset_out_valid", W'(out_valid), 0);
    check("reset_out_fields", {out_result ^ W'({out_tag, out_carry, out_zero, out_ovf, out_sign, out_illegal})}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", W'(in_ready), 1);

    // Directed corner cases
    send(4'd0, '1, 64'd1, 0, 4'd3);
    send(4'd1, 64'h8000_0000_0000_0000, 64'd1, 0, 4'd1);
    send(4'd3, 64'h8000_0000_0000_0000, 64'd0, 6'd63, 4'd2);
    send(4'd5, 64'd1, 64'd0, 6'd63, 4'd4);
    send(4'd2, 64'h1_0000_0000, 64'h1_0000_0000, 0, 4'd5);
    send(4'd15, 64'h1234, 64'h5678, 0, 4'd6);
    send(4'd8, 64'h3, 64'd0, 6'd1, 4'd7);
    send(4'd7, '1, 64'd0, 0, 4'd8);
    send(4'd6, 64'd9, 64'd9, 0, 4'd9);
    wait_empty();

    // Backpressure: only two ops fit while the output is stalled
    @(posedge clk); #1;
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_opcode = 4'd11; in_a = 64'(acc) << 8; in_b = 64'd5; in_shamt = '0; in_tag = TW'(acc);
      @(negedge clk);
      if (in_ready) begin sb.push_back(model(4'd11, 64'(acc) << 8, 64'd5, '0, TW'(acc))); acc++; end
      @(posedge clk); #1;
    end
    check("stall_accepts", W'(acc), 2);
    check("stall_in_ready", W'(in_ready), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && acc < 4; k++) begin
      in_valid = 1'b1; in_opcode = 4'd11; in_a = 64'(acc) << 8; in_b = 64'd5; in_tag = TW'(acc);
      @(negedge clk);
      if (in_ready) begin sb.push_back(model(4'd11, 64'(acc) << 8, 64'd5, '0, TW'(acc))); acc++; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stall_total_accepts", W'(acc), 4);
    wait_empty();

    // Random traffic with random output backpressure
    @(posedge clk); #1;
    rand_done = 0;
    fork
      begin
        for (int n = 0; n < 300; n++)
          send(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand(), SW'($urandom), TW'($urandom));
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_empty();

    // Asynchronous reset with two ops in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'd0, 64'd1, 64'd2, 0, 4'hA);
    send(4'd0, 64'd3, 64'd4, 0, 4'hB);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", W'(out_valid), 0);
    sb.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("post_reset_in_ready", W'(in_ready), 1);
    repeat (5) @(posedge clk);
    #1;
    check("post_reset_no_stale", W'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
